// File: rtl/etc_pwm_driver_pkg.sv
// Shared types and constants for the throttle H-bridge PWM driver.
// Provides the driver state encoding, default timing constants and duty scaling.
package etc_pkg;

    localparam int unsigned DUTY_W       = 16;
    localparam int unsigned MAG_W        = DUTY_W - 1;
    localparam int unsigned DEF_CNT_W    = 13;
    localparam int unsigned DEF_PERIOD   = 5000;
    localparam int unsigned DEF_DEADTIME = 50;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        DEAD = 2'd1,
        FWD  = 2'd2,
        REV  = 2'd3
    } state_t;

    // |duty| saturated to 15 bits (-32768 -> 32767), scaled to cycles: (mag*period) >> 15
    function automatic logic [31:0] duty_to_on(input logic signed [DUTY_W-1:0] duty,
                                               input logic [31:0] period);
        logic [MAG_W-1:0]    mag;
        logic [MAG_W+31:0]   prod;
        if (duty[DUTY_W-1]) begin
            if (duty[DUTY_W-2:0] == '0) mag = '1;
            else                        mag = MAG_W'(-duty);
        end else begin
            mag = MAG_W'(duty);
        end
        prod = (MAG_W+32)'(mag) * (MAG_W+32)'(period);
        return 32'(prod >> MAG_W);
    endfunction

endpackage

// File: rtl/etc_pwm_driver_if.sv
// Command channel from the controller: valid/ready handshake carrying a signed duty.
interface etc_pwm_driver_if;
    import etc_pkg::*;

    logic                     cmd_valid;
    logic                     cmd_ready;
    logic signed [DUTY_W-1:0] cmd_duty;

    modport master (output cmd_valid, output cmd_duty, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_duty, output cmd_ready);

endinterface

// File: rtl/etc_pwm_driver_timebase.sv
// Free-running PWM period counter (0..PERIOD-1) with wrap flag and registered
// period_start pulse that is high while the counter sits at 0.
module etc_pwm_timebase
    import etc_pkg::*;
#(
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned PERIOD = DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] o_cnt_nxt,
    output logic             o_wrap,
    output logic             o_period_start
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;

    assign o_wrap         = (r_cnt == CNT_W'(PERIOD - 1));
    assign o_cnt_nxt      = o_wrap ? '0 : r_cnt + CNT_W'(1);
    assign o_period_start = r_period_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_cnt          <= o_cnt_nxt;
            r_period_start <= o_wrap;
        end
    end

endmodule

// File: rtl/etc_pwm_driver.sv
// Signed throttle command to four H-bridge gates: fixed-period PWM, dead time,
// direction changes via all-off DEAD state. Optional macro: FAULT_LATCH_EN.
module etc_pwm_driver
    import etc_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned DEADTIME = DEF_DEADTIME
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    enable,
    etc_pwm_driver_if.slave         cmd,
    input  logic                    fault_in,
    output logic                    a_hi,
    output logic                    a_lo,
    output logic                    b_hi,
    output logic                    b_lo,
    output logic                    period_start,
    output logic                    fault_latched
);

    logic [CNT_W-1:0]         w_cnt_nxt;
    logic                     w_wrap;
    logic                     r_pend_valid;
    logic signed [DUTY_W-1:0] r_pend_duty;
    logic                     w_accept;
    logic                     w_apply;
    logic [31:0]              r_on;
    logic [31:0]              w_on_nxt;
    logic                     r_duty_neg;
    logic                     w_duty_neg_nxt;
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_dcnt;
    logic [CNT_W-1:0]         w_dcnt_nxt;
    logic                     w_fault_block;
    logic [31:0]              w_c;
    logic                     w_pwm_hi;
    logic                     w_pwm_lo;
    logic                     w_a_hi, w_a_lo, w_b_hi, w_b_lo;
    logic                     r_a_hi, r_a_lo, r_b_hi, r_b_lo;

    etc_pwm_timebase #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_timebase (
        .clk            (clk),
        .rst            (RESET),
        .o_cnt_nxt      (w_cnt_nxt),
        .o_wrap         (w_wrap),
        .o_period_start (period_start)
    );

    assign cmd.cmd_ready = !r_pend_valid;
    assign w_accept      = cmd.cmd_valid && !r_pend_valid;
    assign w_apply       = w_wrap && r_pend_valid;

    // An accept on the wrap cycle finds the buffer empty, so it waits for the next wrap
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_pend_valid <= 1'b0;
            r_pend_duty  <= '0;
        end else if (w_apply) begin
            r_pend_valid <= 1'b0;
        end else if (w_accept) begin
            r_pend_valid <= 1'b1;
            r_pend_duty  <= cmd.cmd_duty;
        end
    end

    assign w_on_nxt       = w_apply ? duty_to_on(r_pend_duty, 32'(PERIOD)) : r_on;
    assign w_duty_neg_nxt = w_apply ? r_pend_duty[DUTY_W-1] : r_duty_neg;

`ifdef FAULT_LATCH_EN
    logic r_fault_d;
    logic r_fault_latched;
    logic w_fault_trip;

    assign w_fault_trip  = fault_in && r_fault_d;
    assign w_fault_block = r_fault_latched || w_fault_trip;
    assign fault_latched = r_fault_latched;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_fault_d       <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_fault_d <= fault_in;
            if (!enable)           r_fault_latched <= 1'b0;
            else if (w_fault_trip) r_fault_latched <= 1'b1;
        end
    end
`else
    logic w_unused_fault;
    assign w_unused_fault = fault_in;
    assign w_fault_block  = 1'b0;
    assign fault_latched  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = '0;
        if (!enable || w_fault_block) begin
            w_state_nxt = OFF;
        end else begin
            unique case (r_state)
                OFF:  if (w_wrap) w_state_nxt = DEAD;
                DEAD: begin
                    if (r_dcnt == CNT_W'(DEADTIME - 1)) w_state_nxt = r_duty_neg ? REV : FWD;
                    else                                w_dcnt_nxt  = r_dcnt + CNT_W'(1);
                end
                FWD:  if (w_apply && r_pend_duty[DUTY_W-1])  w_state_nxt = DEAD;
                REV:  if (w_apply && !r_pend_duty[DUTY_W-1]) w_state_nxt = DEAD;
                default: w_state_nxt = OFF;
            endcase
        end
    end

    // Gates are decoded from next state/count/on so the registered outputs line up with them
    assign w_c      = 32'(w_cnt_nxt);
    assign w_pwm_hi = (w_c < w_on_nxt);
    assign w_pwm_lo = (w_c >= w_on_nxt + DEADTIME) && (w_c < PERIOD - DEADTIME);

    always_comb begin
        w_a_hi = 1'b0;
        w_a_lo = 1'b0;
        w_b_hi = 1'b0;
        w_b_lo = 1'b0;
        unique case (w_state_nxt)
            FWD: begin
                w_a_hi = w_pwm_hi;
                w_a_lo = w_pwm_lo;
                w_b_lo = 1'b1;
            end
            REV: begin
                w_b_hi = w_pwm_hi;
                w_b_lo = w_pwm_lo;
                w_a_lo = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            r_state    <= OFF;
            r_dcnt     <= '0;
            r_on       <= '0;
            r_duty_neg <= 1'b0;
            r_a_hi     <= 1'b0;
            r_a_lo     <= 1'b0;
            r_b_hi     <= 1'b0;
            r_b_lo     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dcnt     <= w_dcnt_nxt;
            r_on       <= w_on_nxt;
            r_duty_neg <= w_duty_neg_nxt;
            r_a_hi     <= w_a_hi;
            r_a_lo     <= w_a_lo;
            r_b_hi     <= w_b_hi;
            r_b_lo     <= w_b_lo;
        end
    end

    assign a_hi = r_a_hi;
    assign a_lo = r_a_lo;
    assign b_hi = r_b_hi;
    assign b_lo = r_b_lo;

endmodule

// File: tb/tb_etc_pwm_driver.sv
// Scoreboard bench for etc_pwm_driver: per-period gate-cycle counts are queued by
// the stimulus and compared by a monitor at every period_start pulse.
module tb_etc_pwm_driver;
    import etc_pkg::*;

    logic clk;
    logic RESET;
    logic enable;
    logic fault_in;
    logic a_hi, a_lo, b_hi, b_lo;
    logic period_start;
    logic fault_latched;

    etc_pwm_driver_if u_if();

    etc_pwm_driver dut (
        .clk           (clk),
        .RESET         (RESET),
        .enable        (enable),
        .cmd           (u_if),
        .fault_in      (fault_in),
        .a_hi          (a_hi),
        .a_lo          (a_lo),
        .b_hi          (b_hi),
        .b_lo          (b_lo),
        .period_start  (period_start),
        .fault_latched (fault_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int ahi;
        int alo;
        int bhi;
        int blo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic hold_win = 1'b0;
    int   n_acc = 0;
    int   n_rlow = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void push_exp(input int tag, input int ahi, input int alo,
                                     input int bhi, input int blo);
        exp_t e;
        e.tag = tag; e.ahi = ahi; e.alo = alo; e.bhi = bhi; e.blo = blo;
        exp_q.push_back(e);
    endfunction

    task automatic wait_ps(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 6000);
        chk({"wait_", name}, int'(period_start), 1);
    endtask

    // Monitor: accumulates gate-cycle counts per period, compares at each wrap
    initial begin
        int p = 0;
        int c_ahi = 0, c_alo = 0, c_bhi = 0, c_blo = 0, c_shoot = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (RESET) begin
                p = 0;
                c_ahi = 0; c_alo = 0; c_bhi = 0; c_blo = 0; c_shoot = 0;
            end else begin
                if (period_start) begin
                    if (exp_q.size() > 0 && exp_q[0].tag == p) begin
                        e = exp_q.pop_front();
                        chk($sformatf("p%0d_a_hi", p), c_ahi, e.ahi);
                        chk($sformatf("p%0d_a_lo", p), c_alo, e.alo);
                        chk($sformatf("p%0d_b_hi", p), c_bhi, e.bhi);
                        chk($sformatf("p%0d_b_lo", p), c_blo, e.blo);
                        chk($sformatf("p%0d_shoot", p), c_shoot, 0);
                    end
                    p++;
                    c_ahi = 0; c_alo = 0; c_bhi = 0; c_blo = 0; c_shoot = 0;
                end
                c_ahi += int'(a_hi);
                c_alo += int'(a_lo);
                c_bhi += int'(b_hi);
                c_blo += int'(b_lo);
                if ((a_hi && a_lo) || (b_hi && b_lo)) c_shoot++;
                if (hold_win) begin
                    if (u_if.cmd_valid && u_if.cmd_ready) n_acc++;
                    if (!u_if.cmd_ready) n_rlow++;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1;
        enable = 1'b0;
        fault_in = 1'b0;
        u_if.cmd_valid = 1'b0;
        u_if.cmd_duty = '0;
        repeat (3) @(negedge clk);
        chk("rst_gates", int'({a_hi, a_lo, b_hi, b_lo}), 0);
        chk("rst_ready", int'(u_if.cmd_ready), 1);
        chk("rst_pstart", int'(period_start), 0);
        chk("rst_fault", int'(fault_latched), 0);

        push_exp(0, 0, 0, 0, 0);
        push_exp(1, 2450, 2400, 0, 4950);
        push_exp(2, 2500, 2400, 0, 5000);
        push_exp(3, 0, 4950, 1200, 3650);
        push_exp(4, 0, 5000, 1250, 3650);
        push_exp(5, 0, 5000, 4999, 0);
        push_exp(6, 0, 5000, 4999, 0);
        push_exp(7, 0, 5000, 4999, 0);
        push_exp(8, 2450, 2400, 0, 4950);

        @(negedge clk);
        RESET = 1'b0;
        enable = 1'b1;
        u_if.cmd_valid = 1'b1;
        u_if.cmd_duty = 16'sd16384;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        chk("ready_after_accept", int'(u_if.cmd_ready), 0);

        wait_ps("p1");
        wait_ps("p2");
        repeat (2500) @(negedge clk);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_duty = -16'sd8192;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;

        wait_ps("p3");
        wait_ps("p4");
        hold_win = 1'b1;
        u_if.cmd_valid = 1'b1;
        u_if.cmd_duty = 16'sh8000;
        wait_ps("p5");
        wait_ps("p6");
        wait_ps("p7");
        hold_win = 1'b0;
        u_if.cmd_duty = 16'sd16384;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        chk("held_accepts", n_acc, 3);
        chk("held_ready_low", n_rlow, 3 * 4999);

        wait_ps("p8");
        wait_ps("p9");
        repeat (1000) @(negedge clk);
        u_if.cmd_valid = 1'b1;
        u_if.cmd_duty = -16'sd8192;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        repeat (1000) @(negedge clk);
        chk("fwd_before_reset_b_lo", int'(b_lo), 1);
        RESET = 1'b1;
        #1;
        chk("midrst_gates", int'({a_hi, a_lo, b_hi, b_lo}), 0);
        chk("midrst_ready", int'(u_if.cmd_ready), 1);
        chk("midrst_pstart", int'(period_start), 0);
        repeat (3) @(negedge clk);

        push_exp(0, 0, 0, 0, 0);
        push_exp(1, 0, 4900, 0, 4950);
        push_exp(2, 0, 4900, 0, 5000);
`ifdef FAULT_LATCH_EN
        push_exp(4, 0, 4900, 0, 4950);
`else
        push_exp(3, 0, 4900, 0, 5000);
`endif
        RESET = 1'b0;

        wait_ps("r1");
        wait_ps("r2");
        wait_ps("r3");
        repeat (1000) @(negedge clk);
        fault_in = 1'b1;
        repeat (2) @(negedge clk);
        fault_in = 1'b0;
`ifdef FAULT_LATCH_EN
        chk("fault_latch", int'(fault_latched), 1);
        chk("fault_gates", int'({a_hi, a_lo, b_hi, b_lo}), 0);
        repeat (10) @(negedge clk);
        chk("fault_hold", int'(fault_latched), 1);
        chk("fault_hold_gates", int'({a_hi, a_lo, b_hi, b_lo}), 0);
        enable = 1'b0;
        @(negedge clk);
        chk("fault_clear", int'(fault_latched), 0);
        enable = 1'b1;
        wait_ps("r4");
        wait_ps("r5");
`else
        chk("fault_ignored_latch", int'(fault_latched), 0);
        chk("fault_ignored_a_lo", int'(a_lo), 1);
        wait_ps("r4");
`endif
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
